piso_tx: RTL and testbench

Parallel-in serial-out transmitter that produces the serial stream consumed by the serial-in shift-register receivers in the shift-register family. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a data-valid qualifier and an end-of-frame pulse. It optionally appends an even-parity bit. It sits between a parallel producer (register file or FIFO) and a serial link.

---
 rtl/piso_tx.sv | 125 ++++++++++++
 tb/tb_piso_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
//   Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
//   MSB-first, one bit per clock, qualified by sdo_valid. done pulses in the
//   cycle the final frame bit is on sdo. A new word may be accepted in that
//   same cycle, so back-to-back frames are gapless.
// Optional feature macro: PISO_PARITY_EN -- appends an even-parity bit (^pdi)
//   after the LSB. done and load_ready then move to that parity cycle.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   load_valid producer has a word on pdi
//   pdi        parallel data in, sampled only on an accepted load
//   load_ready block can accept a word this cycle
//   sdo        serial data out, MSB first
//   sdo_valid  sdo carries a frame bit this cycle
//   busy       a frame is in progress
//   done       final frame bit is on sdo this cycle
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] pdi,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(WIDTH+1) < 1) ? 1 : $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] piso_r, piso_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last_bit;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_r, par_n;
`endif

  // Final frame bit is on sdo: last data bit, or the parity bit if present.
`ifdef PISO_PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (cnt == LAST);
`endif

  // reset_n gates ready so nothing is promised while the block is held.
  assign load_ready = reset_n && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  // Outputs depend on registered state only.
  always_comb begin
    sdo = 1'b0;
    if (state == SHIFT) sdo = piso_r[WIDTH-1];
`ifdef PISO_PARITY_EN
    else if (state == PARITY) sdo = par_r;
`endif
  end

  assign sdo_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign done      = last_bit;

  always_comb begin
    state_n = state;
    piso_n  = piso_r;
    cnt_n   = cnt;
`ifdef PISO_PARITY_EN
    par_n   = par_r;
`endif
    case (state)
      SHIFT: begin
        piso_n = piso_r << 1;
        cnt_n  = cnt + 1'b1;
`ifdef PISO_PARITY_EN
        if (cnt == LAST) state_n = PARITY;
`else
        if (cnt == LAST) state_n = IDLE;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY:  state_n = IDLE;
`endif
      default: ;
    endcase
    // An accepted load overrides the above: IDLE start or seamless reload.
    if (accept) begin
      state_n = SHIFT;
      piso_n  = pdi;
      cnt_n   = '0;
`ifdef PISO_PARITY_EN
      par_n   = ^pdi;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      piso_r <= '0;
      cnt    <= '0;
`ifdef PISO_PARITY_EN
      par_r  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      piso_r <= piso_n;
      cnt    <= cnt_n;
`ifdef PISO_PARITY_EN
      par_r  <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx with a scoreboard of expected
// serial bits. Two instances: WIDTH=8 and WIDTH=1. Expected bits are queued
// when the bench drives an accepted load and popped each cycle.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = 8 + PAR;

  typedef struct packed {
    logic b;
    logic last;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lv8, lv1;
  logic [7:0] pdi8;
  logic [0:0] pdi1;
  logic       rdy8, sdo8, sv8, busy8, done8;
  logic       rdy1, sdo1, sv1, busy1, done1;

  ev_t q8[$];
  ev_t q1[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv8), .pdi(pdi8),
    .load_ready(rdy8), .sdo(sdo8), .sdo_valid(sv8), .busy(busy8), .done(done8)
  );

  piso_tx #(.WIDTH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv1), .pdi(pdi1),
    .load_ready(rdy1), .sdo(sdo1), .sdo_valid(sv1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    ev_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = d[7-i];
      e.last = (PAR == 0) && (i == 7);
      q8.push_back(e);
    end
    if (PAR != 0) begin
      e.b = ^d;
      e.last = 1'b1;
      q8.push_back(e);
    end
  endtask

  task automatic push1(input logic d);
    ev_t e;
    e.b = d;
    e.last = (PAR == 0);
    q1.push_back(e);
    if (PAR != 0) begin
      e.b = d;
      e.last = 1'b1;
      q1.push_back(e);
    end
  endtask

  // One cycle of the WIDTH=8 instance: drive inputs, check outputs against
  // the scoreboard, record an accepted load, advance to just after the edge.
  task automatic cyc8(input logic v, input logic [7:0] d);
    logic exp_rdy;
    ev_t  e;
    lv8 = v;
    pdi8 = d;
    exp_rdy = (q8.size() <= 1);
    chk("w8_ready", {7'd0, rdy8}, {7'd0, exp_rdy});
    chk("w8_busy", {7'd0, busy8}, {7'd0, q8.size() != 0});
    chk("w8_valid", {7'd0, sv8}, {7'd0, q8.size() != 0});
    if (q8.size() != 0) begin
      e = q8.pop_front();
      chk("w8_sdo", {7'd0, sdo8}, {7'd0, e.b});
      chk("w8_done", {7'd0, done8}, {7'd0, e.last});
    end else begin
      chk("w8_sdo_idle", {7'd0, sdo8}, 8'd0);
      chk("w8_done_idle", {7'd0, done8}, 8'd0);
    end
    if (v && exp_rdy) push8(d);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic v, input logic d);
    logic exp_rdy;
    ev_t  e;
    lv1 = v;
    pdi1 = d;
    exp_rdy = (q1.size() <= 1);
    chk("w1_ready", {7'd0, rdy1}, {7'd0, exp_rdy});
    chk("w1_valid", {7'd0, sv1}, {7'd0, q1.size() != 0});
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("w1_sdo", {7'd0, sdo1}, {7'd0, e.b});
      chk("w1_done", {7'd0, done1}, {7'd0, e.last});
    end else begin
      chk("w1_sdo_idle", {7'd0, sdo1}, 8'd0);
      chk("w1_done_idle", {7'd0, done1}, 8'd0);
    end
    if (v && exp_rdy) push1(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    lv8 = 1'b0; pdi8 = 8'd0;
    lv1 = 1'b0; pdi1 = 1'b0;
    #3;
    // Reset state
    chk("rst_ready8", {7'd0, rdy8}, 8'd0);
    chk("rst_sdo8", {7'd0, sdo8}, 8'd0);
    chk("rst_valid8", {7'd0, sv8}, 8'd0);
    chk("rst_busy8", {7'd0, busy8}, 8'd0);
    chk("rst_done8", {7'd0, done8}, 8'd0);
    chk("rst_ready1", {7'd0, rdy1}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

    // Single frame 0xA5
    cyc8(1'b1, 8'hA5);
    repeat (FLEN + 2) cyc8(1'b0, 8'h00);

    // Back-to-back: 0x3C held valid, accepted only in the final-bit cycle
    for (int i = 0; i <= FLEN; i++) cyc8(1'b1, (i == 0) ? 8'hA5 : 8'h3C);
    repeat (FLEN + 2) cyc8(1'b0, 8'h00);

    // Load while busy is ignored
    cyc8(1'b1, 8'hA5);
    cyc8(1'b0, 8'h00);
    cyc8(1'b0, 8'h00);
    cyc8(1'b1, 8'hFF);
    repeat (FLEN + 2) cyc8(1'b0, 8'h00);

    // Reset mid-frame (during cycle N+4)
    cyc8(1'b1, 8'hA5);
    repeat (3) cyc8(1'b0, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("midrst_sdo", {7'd0, sdo8}, 8'd0);
    chk("midrst_valid", {7'd0, sv8}, 8'd0);
    chk("midrst_busy", {7'd0, busy8}, 8'd0);
    chk("midrst_done", {7'd0, done8}, 8'd0);
    chk("midrst_ready", {7'd0, rdy8}, 8'd0);
    q8.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("postrst_ready", {7'd0, rdy8}, 8'd1);
    chk("postrst_done", {7'd0, done8}, 8'd0);
    cyc8(1'b1, 8'h3C);
    repeat (FLEN + 2) cyc8(1'b0, 8'h00);

    // Parity-sensitive words (odd and even popcount), back-to-back
    cyc8(1'b1, 8'hA5);
    for (int i = 1; i <= FLEN; i++) cyc8(1'b1, 8'h07);
    repeat (FLEN + 2) cyc8(1'b0, 8'h00);

    // WIDTH=1: 1,0,1 back-to-back
    cyc1(1'b1, 1'b1);
    if (PAR != 0) cyc1(1'b1, 1'b0);
    cyc1(1'b1, 1'b0);
    if (PAR != 0) cyc1(1'b1, 1'b1);
    cyc1(1'b1, 1'b1);
    repeat (4) cyc1(1'b0, 1'b0);

    chk("sb8_empty", 8'(q8.size()), 8'd0);
    chk("sb1_empty", 8'(q1.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
